uart_receiver: RTL

- 8N1 UART receiver; the receive-side counterpart of the SOC's UART emitter. Lives in the SOC IO page beside it.
- Samples asynchronous RXD and reassembles bytes.
- Buffers received bytes in a small FIFO and hands them to the CPU read path over a valid/ready handshake.
- Reports framing errors and overrun as sticky flags, readable through the IO status word.

---
 rtl/uart_receiver_if.sv | 10 +
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Byte hand-off from the UART receive FIFO head to its consumer.
// The receiver drives the master side; the CPU read path is the slave.
interface uart_receiver_if;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;

   modport master (output o_data, output o_valid, input i_ready);
   modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop RXD synchronizer, mid-bit sampling FSM, small receive FIFO
// with a registered head, and sticky framing-error / overrun flags.
module uart_receiver #(
   parameter int unsigned clk_freq_hz = 100_000_000,
   parameter int unsigned baud_rate   = 1_000_000,
   parameter int unsigned fifo_depth  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx,
   input  logic                   i_clr_err,
   uart_receiver_if.master        io_rd,
   output logic                   o_frame_err,
   output logic                   o_overrun,
   output logic                   o_busy
);
   localparam int unsigned CLKS_PER_BIT = clk_freq_hz / baud_rate;
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW           = $clog2(fifo_depth);
   localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          r_rx_meta, r_rx_s;
   logic [1:0]    r_fill;
   logic          r_armed;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_busy;
   logic [7:0]    r_mem [fifo_depth];
   logic [AW:0]   r_wr_ptr, r_rd_ptr;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frame_err, r_overrun;

   logic          w_cnt_zero, w_stop_tick, w_push, w_bad_stop;
   logic          w_full, w_pop, w_push_ok, w_drop;
   logic [AW:0]   w_wr_next, w_rd_next;

   assign w_cnt_zero  = (r_cnt == '0);
   assign w_stop_tick = (r_state == S_STOP) && w_cnt_zero;
   assign w_push      = w_stop_tick & r_rx_s;
   assign w_bad_stop  = w_stop_tick & ~r_rx_s;

   assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop     = r_valid & io_rd.i_ready;
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_drop    = w_push & w_full & ~w_pop;
   assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
   assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

   // NOTE: synchronizer resets to the idle-high line level; r_fill holds off arming until
   // both flops carry real samples, so a line held low through reset never looks like a start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_fill    <= 2'b00;
         r_armed   <= 1'b0;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_fill    <= {r_fill[0], 1'b1};
         if (r_fill[1] && r_rx_s) r_armed <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_armed && !r_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= HALF_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - CW'(1);
               end else if (r_rx_s) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state   <= S_DATA;
                  r_cnt     <= FULL_LOAD;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_shift   <= {r_rx_s, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  r_cnt     <= FULL_LOAD;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
               end
            end
            S_STOP: begin
               // Leave at mid-stop so a start bit right behind this frame is not missed.
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; validity is tracked entirely by the pointers.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_next;
         r_rd_ptr <= w_rd_next;
         r_valid  <= (w_wr_next != w_rd_next);
         // Bypass the byte being written when it lands directly in the head slot.
         if (w_push_ok && (r_wr_ptr == w_rd_next))
            r_data <= r_shift;
         else if (w_pop && (w_wr_next != w_rd_next))
            r_data <= r_mem[w_rd_next[AW-1:0]];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_bad_stop)     r_frame_err <= 1'b1;
         else if (i_clr_err) r_frame_err <= 1'b0;
         if (w_drop)         r_overrun   <= 1'b1;
         else if (i_clr_err) r_overrun   <= 1'b0;
      end
   end

   assign io_rd.o_data  = r_data;
   assign io_rd.o_valid = r_valid;
   assign o_frame_err   = r_frame_err;
   assign o_overrun     = r_overrun;
   assign o_busy        = r_busy;
endmodule
